// File: rtl/fxm_disp_pkg.sv
// Shared types, segment patterns and the double-dabble step for the frequency display.
package fxm_disp_pkg;
  localparam int BCD_W = 20;
  localparam int NITER = 16;
  localparam int SH_W  = BCD_W + NITER;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // gfedcba, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = SEG_0;
      4'd1: seg_of = SEG_1;
      4'd2: seg_of = SEG_2;
      4'd3: seg_of = SEG_3;
      4'd4: seg_of = SEG_4;
      4'd5: seg_of = SEG_5;
      4'd6: seg_of = SEG_6;
      4'd7: seg_of = SEG_7;
      4'd8: seg_of = SEG_8;
      4'd9: seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble >= 5, applied before each shift.
  function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_W/4; i++)
      if (r[NITER+4*i +: 4] >= 4'd5) r[NITER+4*i +: 4] = r[NITER+4*i +: 4] + 4'd3;
    return r;
  endfunction
endpackage

// File: rtl/fxm_display_if.sv
// Load/result handshake between the measurement stage and the display block.
interface fxm_display_if;
  logic        load;
  logic [15:0] din;
  logic        busy;
  logic        ovf;

  modport master (output load, din, input busy, ovf);
  modport slave  (input load, din, output busy, ovf);
endinterface

// File: rtl/bin2bcd16.sv
// Iterative 16-bit binary to 5-digit BCD converter with a one-deep pending slot.
module bin2bcd16
  import fxm_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      din,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  state_t          state, state_d;
  logic [4:0]      cnt;
  logic [SH_W-1:0] sh;
  logic            pend_vld;
  logic [15:0]     pend;

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt == 5'(NITER-1)) state_d = DONE;
      DONE:    state_d = (start || pend_vld) ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    bcd  = sh[SH_W-1 -: BCD_W];
  end

  // A load on the DONE cycle is the newest value and supersedes the pending one.
  always_ff @(posedge clk)
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh  <= {{BCD_W{1'b0}}, din};
          cnt <= '0;
        end
        SHIFT: begin
          sh  <= dabble(sh) << 1;
          cnt <= cnt + 5'd1;
          if (start) begin
            pend     <= din;
            pend_vld <= 1'b1;
          end
        end
        DONE: begin
          cnt      <= '0;
          pend_vld <= 1'b0;
          if (start)         sh <= {{BCD_W{1'b0}}, din};
          else if (pend_vld) sh <= {{BCD_W{1'b0}}, pend};
        end
        default: ;
      endcase
    end
endmodule

// File: rtl/fxm_display.sv
// Frequency display: BCD conversion, display register and 4-digit multiplexed 7-seg scan.
module fxm_display
  import fxm_disp_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1,
  parameter int SCAN_DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce1ms,
  fxm_display_if.slave bus,
  output logic [3:0]   AN,
  output logic [6:0]   seg,
  output logic         seg_P
);
  logic             done;
  logic [BCD_W-1:0] bcd, disp;
  logic [7:0]       div;
  logic [1:0]       idx;
  logic [3:0]       digit, lz;
  logic [6:0]       seg_d;

  bin2bcd16 u_conv (
    .clk  (clk),
    .rst  (rst),
    .start(bus.load),
    .din  (bus.din),
    .busy (bus.busy),
    .done (done),
    .bcd  (bcd)
  );

  always_ff @(posedge clk)
    if (rst)       disp <= '0;
    else if (done) disp <= bcd;

  assign bus.ovf = |disp[19:16];

  always_ff @(posedge clk)
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (ce1ms) begin
      if (div == 8'(SCAN_DIV-1)) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 8'd1;
      end
    end

  // lz[i]: digit i and everything above it is zero.
  always_comb begin
    lz[3] = (disp[15:12] == 4'd0);
    lz[2] = lz[3] && (disp[11:8] == 4'd0);
    lz[1] = lz[2] && (disp[7:4] == 4'd0);
    lz[0] = 1'b0;
    case (idx)
      2'd0:    digit = disp[3:0];
      2'd1:    digit = disp[7:4];
      2'd2:    digit = disp[11:8];
      default: digit = disp[15:12];
    endcase
    seg_d = seg_of(digit);
    if (bus.ovf)                   seg_d = SEG_DASH;
    else if (BLANK_LZ && lz[idx])  seg_d = SEG_BLANK;
  end

  always_ff @(posedge clk)
    if (rst) begin
      AN  <= 4'b1110;
      seg <= SEG_0;
    end else begin
      AN  <= ~(4'b0001 << idx);
      seg <= seg_d;
    end

  assign seg_P = 1'b1;
endmodule

// File: tb/tb_fxm_display.sv
// Random + directed bench for fxm_display against a cycle-level arithmetic reference model.
module tb_fxm_display;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst = 1'b1, ce1ms = 1'b0, load = 1'b0;
  logic [15:0] din = '0;

  fxm_display_if bus0 ();
  fxm_display_if bus1 ();
  assign bus0.load = load;
  assign bus0.din  = din;
  assign bus1.load = load;
  assign bus1.din  = din;

  logic [3:0] an0, an1;
  logic [6:0] sg0, sg1;
  logic       dp0, dp1;

  fxm_display #(.BLANK_LZ(1'b1), .SCAN_DIV(1)) u_dut0 (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .bus(bus0), .AN(an0), .seg(sg0), .seg_P(dp0));
  fxm_display #(.BLANK_LZ(1'b0), .SCAN_DIV(2)) u_dut1 (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .bus(bus1), .AN(an1), .seg(sg1), .seg_P(dp1));

  localparam logic [6:0] SEGTAB [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam int SD [2] = '{1, 2};
  localparam bit BL [2] = '{1'b1, 1'b0};

  int n_cmp = 0, n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int pos, input int val, input bit blz);
    int pw;
    pw = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
    if (val > 9999)                   return 7'b0111111;
    if (blz && pos > 0 && val < pw)   return 7'b1111111;
    return SEGTAB[(val / pw) % 10];
  endfunction

  // Reference model: a conversion is an age counter (16 shift edges, commit on the 17th).
  bit         m_act = 0, m_pv = 0;
  int         m_age = 0, m_cur = 0, m_pend = 0, m_disp = 0;
  int         m_idx [2] = '{0, 0};
  int         m_div [2] = '{0, 0};
  logic [3:0] m_an  [2] = '{4'b1110, 4'b1110};
  logic [6:0] m_seg [2] = '{7'b1000000, 7'b1000000};

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_pv = 0; m_age = 0; m_disp = 0;
      for (int k = 0; k < 2; k++) begin
        m_idx[k] = 0; m_div[k] = 0; m_an[k] = 4'b1110; m_seg[k] = SEGTAB[0];
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_an[k]  = ~(4'b0001 << m_idx[k]);
        m_seg[k] = exp_seg(m_idx[k], m_disp, BL[k]);
        if (ce1ms) begin
          m_div[k]++;
          if (m_div[k] == SD[k]) begin
            m_div[k] = 0;
            m_idx[k] = (m_idx[k] + 1) % 4;
          end
        end
      end
      if (m_act) begin
        m_age++;
        if (m_age <= 16) begin
          if (load) begin m_pv = 1; m_pend = int'(din); end
        end else begin
          m_disp = m_cur;
          if (load)      begin m_cur = int'(din); m_age = 0; m_pv = 0; end
          else if (m_pv) begin m_cur = m_pend;    m_age = 0; m_pv = 0; end
          else m_act = 0;
        end
      end else if (load) begin
        m_act = 1; m_age = 0; m_cur = int'(din);
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("busy0", 32'(bus0.busy), 32'(m_act));
    chk("busy1", 32'(bus1.busy), 32'(m_act));
    chk("ovf0",  32'(bus0.ovf),  32'(m_disp > 9999));
    chk("ovf1",  32'(bus1.ovf),  32'(m_disp > 9999));
    chk("an0",   32'(an0), 32'(m_an[0]));
    chk("seg0",  32'(sg0), 32'(m_seg[0]));
    chk("an1",   32'(an1), 32'(m_an[1]));
    chk("seg1",  32'(sg1), 32'(m_seg[1]));
    chk("dp",    32'({dp1, dp0}), 32'd3);
  end

  task automatic cyc(input bit l, input logic [15:0] d, input bit c, input bit r);
    @(negedge clk);
    load = l; din = d; ce1ms = c; rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic scan(input int n);
    repeat (n) begin
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      cyc(1'b0, 16'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic show(input logic [15:0] v);
    cyc(1'b1, v, 1'b0, 1'b0);
    idle(19);
    scan(8);
  endtask

  initial begin
    int bl;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_an",  32'(an0), 32'h0000000e);
    chk("rst_seg", 32'(sg0), 32'h00000040);
    idle(1);
    scan(4);

    // Isolated load: busy must be high for exactly 17 cycles.
    cyc(1'b1, 16'd1234, 1'b0, 1'b0);
    bl = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1'b0);
      if (bus0.busy) bl++;
    end
    chk("busy_len", 32'(bl), 32'd17);
    scan(8);

    show(16'd7);
    show(16'd9999);
    show(16'd10000);
    show(16'd65535);
    show(16'd0);

    // Overlap: 42 lands in pending and is overwritten by 99.
    cyc(1'b1, 16'd1234, 1'b0, 1'b0); idle(4);
    cyc(1'b1, 16'd42, 1'b0, 1'b0);   idle(7);
    cyc(1'b1, 16'd99, 1'b0, 1'b0);   idle(25);
    scan(4);

    // Load on the DONE cycle preempts the pending value.
    cyc(1'b1, 16'd321, 1'b0, 1'b0); idle(4);
    cyc(1'b1, 16'd555, 1'b0, 1'b0); idle(11);
    cyc(1'b1, 16'd8765, 1'b0, 1'b0); idle(25);
    scan(4);

    // Reset mid-conversion, then a clean conversion.
    cyc(1'b1, 16'd1234, 1'b0, 1'b0); idle(7);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);    idle(25);
    show(16'd56);

    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 8) == 0,
          ($urandom % 3 == 0) ? 16'($urandom % 10000) : 16'($urandom),
          ($urandom % 3) == 0,
          ($urandom % 300) == 0);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
